img_stage_arb: RTL and testbench

IMG_STAGE_ARB -- requirements
Module: img_stage_arb

---
 rtl/img_pipe_pkg.sv | 23 ++
 rtl/img_stage_arb_if.sv | 28 ++
 rtl/img_arb_timer.sv | 27 ++
 rtl/img_stage_arb.sv | 151 +++++++++++++++
 tb/tb_img_stage_arb.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/img_pipe_pkg.sv
// Shared constants for the image-stage arbiter: FSM encoding, source selects,
// default timeout and the round-robin pick helper.
package img_pipe_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ISSUE   = 2'd1;
    localparam logic [1:0] ST_DONE    = 2'd2;
    localparam logic [1:0] ST_RELEASE = 2'd3;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    localparam int TIMEOUT_CYCLES_DEF = 1024;

    // Both requesting: the source not granted last wins; a lone requester always wins.
    function automatic logic rr_pick(input logic req_a, input logic req_b, input logic last_grant);
        if (req_a && req_b) begin
            return ~last_grant;
        end
        return req_a ? SEL_A : SEL_B;
    endfunction

endpackage

// File: rtl/img_stage_arb_if.sv
// Handshake and status bundle between two frame sources, the shared stage and
// the arbiter. The slave modport is the arbiter's view.
interface img_stage_arb_if #(
    parameter int CNT_W = 16
);
    logic             ReqA;
    logic             ReqB;
    logic             AckA;
    logic             AckB;
    logic             StageReq;
    logic             StageAck;
    logic             Sel;
    logic             Busy;
    logic [CNT_W-1:0] FrameCntA;
    logic [CNT_W-1:0] FrameCntB;
    logic             TimeoutErr;
    logic             ClrErr;

    modport master (
        output ReqA, ReqB, StageAck, ClrErr,
        input  AckA, AckB, StageReq, Sel, Busy, FrameCntA, FrameCntB, TimeoutErr
    );

    modport slave (
        input  ReqA, ReqB, StageAck, ClrErr,
        output AckA, AckB, StageReq, Sel, Busy, FrameCntA, FrameCntB, TimeoutErr
    );
endinterface

// File: rtl/img_arb_timer.sv
// ISSUE-phase watchdog: counts cycles while start is high; expired flags the
// LIMIT-th counted cycle. Only instantiated when IMG_ARB_TIMEOUT_EN is defined.
module img_arb_timer #(
    parameter int LIMIT = 1024
) (
    input  logic Clk,
    input  logic Reset,
    input  logic start,
    input  logic clear,
    output logic expired
);
    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] cnt_q;

    assign expired = start && (cnt_q == CW'(LIMIT - 1));

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (start) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end
endmodule

// File: rtl/img_stage_arb.sv
// Round-robin arbiter granting sources A/B four-phase access to a shared stage.
// Optional ISSUE timeout with sticky error when IMG_ARB_TIMEOUT_EN is defined.
module img_stage_arb
    import img_pipe_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    parameter int CNT_W          = 16
) (
    input  logic           Clk,
    input  logic           Reset,
    img_stage_arb_if.slave bus
);
    logic [1:0] state_q, state_d;
    logic       sel_q, sel_d;
    logic       last_q, last_d;
    logic       stage_req_q, stage_req_d;
    logic [1:0] ack_q, ack_d;
    logic       busy_q;
    logic [1:0] cnt_inc;
    logic [1:0] req;
    logic       winner;
    logic       timeout_hit;
    logic       timed_out_q;

    assign req    = {bus.ReqB, bus.ReqA};
    assign winner = rr_pick(bus.ReqA, bus.ReqB, last_q);

`ifdef IMG_ARB_TIMEOUT_EN
    logic err_q;
    logic set_err;

    img_arb_timer #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_timer (
        .Clk     (Clk),
        .Reset   (Reset),
        .start   (state_q == ST_ISSUE),
        .clear   (state_q != ST_ISSUE),
        .expired (timeout_hit)
    );

    // A stage acknowledge on the expiry edge takes precedence over the timeout.
    assign set_err = (state_q == ST_ISSUE) && !bus.StageAck && timeout_hit;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            err_q       <= 1'b0;
            timed_out_q <= 1'b0;
        end else begin
            if (set_err) begin
                err_q <= 1'b1;
            end else if (bus.ClrErr) begin
                err_q <= 1'b0;
            end
            if (set_err) begin
                timed_out_q <= 1'b1;
            end else if (state_q == ST_IDLE) begin
                timed_out_q <= 1'b0;
            end
        end
    end

    assign bus.TimeoutErr = err_q;
`else
    assign timeout_hit    = 1'b0;
    assign timed_out_q    = 1'b0;
    assign bus.TimeoutErr = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        last_d      = last_q;
        stage_req_d = stage_req_q;
        ack_d       = ack_q;
        cnt_inc     = '0;
        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    sel_d       = winner;
                    stage_req_d = 1'b1;
                    state_d     = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (bus.StageAck) begin
                    ack_d[sel_q] = 1'b1;
                    state_d      = ST_DONE;
                end else if (timeout_hit) begin
                    ack_d[sel_q] = 1'b1;
                    stage_req_d  = 1'b0;
                    state_d      = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!req[sel_q]) begin
                    ack_d[sel_q] = 1'b0;
                    stage_req_d  = 1'b0;
                    state_d      = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (!bus.StageAck) begin
                    last_d         = sel_q;
                    cnt_inc[sel_q] = !timed_out_q;
                    state_d        = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Last-grant resets to B so that A wins the first contested round.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q     <= ST_IDLE;
            sel_q       <= SEL_A;
            last_q      <= SEL_B;
            stage_req_q <= 1'b0;
            ack_q       <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            last_q      <= last_d;
            stage_req_q <= stage_req_d;
            ack_q       <= ack_d;
            busy_q      <= (state_d != ST_IDLE);
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
        logic [CNT_W-1:0] cnt_q;

        always_ff @(posedge Clk or negedge Reset) begin
            if (!Reset) begin
                cnt_q <= '0;
            end else if (cnt_inc[gi]) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.AckA      = ack_q[0];
    assign bus.AckB      = ack_q[1];
    assign bus.StageReq  = stage_req_q;
    assign bus.Sel       = sel_q;
    assign bus.Busy      = busy_q;
    assign bus.FrameCntA = g_cnt[0].cnt_q;
    assign bus.FrameCntB = g_cnt[1].cnt_q;
endmodule

// File: tb/tb_img_stage_arb.sv
// Directed bench for img_stage_arb (2-bit counters, 8-cycle timeout); the
// timeout scenario runs when IMG_ARB_TIMEOUT_EN is defined.
module tb_img_stage_arb;
    logic Clk;
    logic Reset;
    int   n_vec;
    int   n_miss;

    img_stage_arb_if #(.CNT_W(2)) bus_if ();

    img_stage_arb #(
        .TIMEOUT_CYCLES (8),
        .CNT_W          (2)
    ) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus_if.slave)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        $display("vec %0d %s: observed %0h expected %0h", n_vec, tag, obs, exp);
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        bus_if.ReqA     = 1'b0;
        bus_if.ReqB     = 1'b0;
        bus_if.StageAck = 1'b0;
        bus_if.ClrErr   = 1'b0;
        Reset           = 1'b0;
        repeat (2) tick();
        Reset = 1'b1;
        tick();
    endtask

    task automatic wait_stage_req(input string tag);
        int k;
        k = 0;
        while (bus_if.StageReq !== 1'b1 && k < 10) begin
            tick();
            k++;
        end
        check({tag, "_stage_req"}, 32'(bus_if.StageReq), 32'd1);
    endtask

    // One full handshake; the caller raises the request(s), the winner's is dropped here.
    task automatic run_frame(input string tag, input logic exp_sel, input int ack_delay,
                             input logic [1:0] exp_cnt);
        wait_stage_req(tag);
        check({tag, "_sel"}, 32'(bus_if.Sel), 32'(exp_sel));
        check({tag, "_busy"}, 32'(bus_if.Busy), 32'd1);
        repeat (ack_delay) tick();
        check({tag, "_ack_early"}, 32'({bus_if.AckB, bus_if.AckA}), 32'd0);
        bus_if.StageAck = 1'b1;
        tick();
        check({tag, "_ack"}, 32'({bus_if.AckB, bus_if.AckA}), exp_sel ? 32'd2 : 32'd1);
        if (exp_sel) bus_if.ReqB = 1'b0;
        else         bus_if.ReqA = 1'b0;
        tick();
        check({tag, "_ack_drop"}, 32'({bus_if.AckB, bus_if.AckA, bus_if.StageReq}), 32'd0);
        check({tag, "_sel_hold"}, 32'(bus_if.Sel), 32'(exp_sel));
        bus_if.StageAck = 1'b0;
        tick();
        check({tag, "_idle"}, 32'(bus_if.Busy), 32'd0);
        check({tag, "_cnt"}, 32'(exp_sel ? bus_if.FrameCntB : bus_if.FrameCntA), 32'(exp_cnt));
    endtask

    initial begin
        n_vec  = 0;
        n_miss = 0;

        // Reset state
        do_reset();
        check("rst_outputs",
              32'({bus_if.AckA, bus_if.AckB, bus_if.StageReq, bus_if.Sel, bus_if.Busy,
                   bus_if.TimeoutErr}), 32'd0);
        check("rst_cnt", 32'({bus_if.FrameCntA, bus_if.FrameCntB}), 32'd0);

        // Single A frame, stage acknowledges three cycles after StageReq
        bus_if.ReqA = 1'b1;
        run_frame("a_single", 1'b0, 3, 2'd1);

        // Contention from reset: A first, then B, then A again
        do_reset();
        bus_if.ReqA = 1'b1;
        bus_if.ReqB = 1'b1;
        run_frame("rr_a", 1'b0, 1, 2'd1);
        run_frame("rr_b", 1'b1, 2, 2'd1);
        check("rr_cnt_a", 32'(bus_if.FrameCntA), 32'd1);
        bus_if.ReqA = 1'b1;
        bus_if.ReqB = 1'b1;
        run_frame("rr_a2", 1'b0, 1, 2'd2);
        run_frame("rr_b2", 1'b1, 1, 2'd2);

        // Lone B, three back-to-back frames
        do_reset();
        bus_if.ReqB = 1'b1;
        run_frame("b1", 1'b1, 1, 2'd1);
        bus_if.ReqB = 1'b1;
        run_frame("b2", 1'b1, 2, 2'd2);
        bus_if.ReqB = 1'b1;
        run_frame("b3", 1'b1, 0, 2'd3);
        check("b_cnt_a", 32'(bus_if.FrameCntA), 32'd0);

        // Counter wrap with 2-bit counters
        do_reset();
        bus_if.ReqA = 1'b1; run_frame("wrap1", 1'b0, 1, 2'd1);
        bus_if.ReqA = 1'b1; run_frame("wrap2", 1'b0, 1, 2'd2);
        bus_if.ReqA = 1'b1; run_frame("wrap3", 1'b0, 1, 2'd3);
        bus_if.ReqA = 1'b1; run_frame("wrap4", 1'b0, 1, 2'd0);
        bus_if.ReqA = 1'b1; run_frame("wrap5", 1'b0, 1, 2'd1);
        check("wrap_err", 32'(bus_if.TimeoutErr), 32'd0);

        // Asynchronous reset while in DONE for source B
        do_reset();
        bus_if.ReqB = 1'b1;
        wait_stage_req("mid");
        bus_if.StageAck = 1'b1;
        tick();
        check("mid_ackb", 32'(bus_if.AckB), 32'd1);
        #2;
        Reset = 1'b0;
        #1;
        check("mid_async_outs",
              32'({bus_if.AckA, bus_if.AckB, bus_if.StageReq, bus_if.Sel, bus_if.Busy}), 32'd0);
        bus_if.ReqB     = 1'b0;
        bus_if.StageAck = 1'b0;
        tick();
        Reset = 1'b1;
        tick();
        bus_if.ReqA = 1'b1;
        run_frame("post_rst", 1'b0, 1, 2'd1);
        check("post_rst_cnt_b", 32'(bus_if.FrameCntB), 32'd0);

`ifdef IMG_ARB_TIMEOUT_EN
        // StageAck never arrives: timeout after 8 ISSUE cycles, no count
        do_reset();
        bus_if.ReqA = 1'b1;
        wait_stage_req("to");
        repeat (7) tick();
        check("to_pre", 32'({bus_if.TimeoutErr, bus_if.AckA, bus_if.StageReq}), 32'd1);
        tick();
        check("to_hit", 32'({bus_if.TimeoutErr, bus_if.AckA, bus_if.StageReq}), 32'd6);
        bus_if.ReqA = 1'b0;
        repeat (2) tick();
        check("to_idle", 32'(bus_if.Busy), 32'd0);
        check("to_cnt", 32'(bus_if.FrameCntA), 32'd0);
        check("to_sticky", 32'(bus_if.TimeoutErr), 32'd1);
        bus_if.ClrErr = 1'b1;
        tick();
        bus_if.ClrErr = 1'b0;
        check("to_clr", 32'(bus_if.TimeoutErr), 32'd0);
        // Second timeout with ClrErr on the expiry edge: set wins
        bus_if.ReqA = 1'b1;
        wait_stage_req("to2");
        repeat (7) tick();
        bus_if.ClrErr = 1'b1;
        tick();
        bus_if.ClrErr = 1'b0;
        check("to2_set_wins", 32'(bus_if.TimeoutErr), 32'd1);
        bus_if.ReqA = 1'b0;
        repeat (2) tick();
        check("to2_cnt", 32'(bus_if.FrameCntA), 32'd0);
`else
        // Without the timeout option ISSUE waits indefinitely
        do_reset();
        bus_if.ReqA = 1'b1;
        wait_stage_req("nto");
        repeat (20) tick();
        check("nto_wait",
              32'({bus_if.TimeoutErr, bus_if.AckA, bus_if.StageReq, bus_if.Busy}), 32'd3);
        bus_if.StageAck = 1'b1;
        tick();
        check("nto_ack", 32'(bus_if.AckA), 32'd1);
        bus_if.ReqA = 1'b0;
        tick();
        bus_if.StageAck = 1'b0;
        tick();
        check("nto_cnt", 32'(bus_if.FrameCntA), 32'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
